// File: rtl/sign_extend.sv
// Immediate extension unit: sign/zero/upper/byte/branch-offset forms of A onto B.
// Define SIGN_EXTEND_REG_OUT_EN to add one output register stage (latency 1).
module sign_extend #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  A,
    input  logic [2:0]       mode,
    input  logic             in_valid,
    output logic [OUT_W-1:0] B,
    output logic             out_valid,
    output logic             sign_bit
);

    logic [OUT_W-1:0] ext_result;
    logic             ext_fill;

    // Modes 110/111 are unused encodings and fall back to plain sign extension.
    always_comb begin
        ext_result = '0;
        ext_fill   = 1'b0;
        case (mode)
            3'b001: begin
                ext_result = {{(OUT_W-IN_W){1'b0}}, A};
            end
            3'b010: begin
                ext_result = {A, {(OUT_W-IN_W){1'b0}}};
            end
            3'b011: begin
                ext_fill   = A[7];
                ext_result = {{(OUT_W-8){A[7]}}, A[7:0]};
            end
            3'b100: begin
                ext_result = {{(OUT_W-8){1'b0}}, A[7:0]};
            end
            3'b101: begin
                ext_fill   = A[IN_W-1];
                ext_result = {{(OUT_W-IN_W-2){A[IN_W-1]}}, A, 2'b00};
            end
            default: begin
                ext_fill   = A[IN_W-1];
                ext_result = {{(OUT_W-IN_W){A[IN_W-1]}}, A};
            end
        endcase
    end

`ifdef SIGN_EXTEND_REG_OUT_EN
    // Result and fill bit only load on qualified cycles so B holds between transactions.
    always_ff @(posedge clk) begin
        if (rst) begin
            B         <= '0;
            sign_bit  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                B        <= ext_result;
                sign_bit <= ext_fill;
            end
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst};

    assign B         = ext_result;
    assign sign_bit  = ext_fill;
    assign out_valid = in_valid;
`endif

endmodule

// File: tb/tb_sign_extend.sv
// Directed self-checking bench for sign_extend; follows SIGN_EXTEND_REG_OUT_EN
// to decide whether results are sampled immediately or one edge later.
module tb_sign_extend;

    logic        clk;
    logic        rst;
    logic [15:0] A;
    logic [2:0]  mode;
    logic        in_valid;
    logic [31:0] B;
    logic        out_valid;
    logic        sign_bit;

    int check_count = 0;
    int fail_count  = 0;

    typedef struct {
        logic [2:0]  mode;
        logic [15:0] a;
        logic [31:0] b;
        logic        sb;
    } vec_t;

    vec_t vecs [14] = '{
        '{3'b000, 16'h7FFF, 32'h00007FFF, 1'b0},
        '{3'b000, 16'h8000, 32'hFFFF8000, 1'b1},
        '{3'b001, 16'h8000, 32'h00008000, 1'b0},
        '{3'b010, 16'h1234, 32'h12340000, 1'b0},
        '{3'b011, 16'h0080, 32'hFFFFFF80, 1'b1},
        '{3'b100, 16'h00FF, 32'h000000FF, 1'b0},
        '{3'b101, 16'hFFFF, 32'hFFFFFFFC, 1'b1},
        '{3'b101, 16'h0001, 32'h00000004, 1'b0},
        '{3'b110, 16'h8001, 32'hFFFF8001, 1'b1},
        '{3'b111, 16'h1234, 32'h00001234, 1'b0},
        '{3'b011, 16'hFF7F, 32'h0000007F, 1'b0},
        '{3'b100, 16'hFF80, 32'h00000080, 1'b0},
        '{3'b010, 16'hFFFF, 32'hFFFF0000, 1'b0},
        '{3'b101, 16'h8000, 32'hFFFE0000, 1'b1}
    };

    sign_extend #(.IN_W(16), .OUT_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .mode      (mode),
        .in_valid  (in_valid),
        .B         (B),
        .out_valid (out_valid),
        .sign_bit  (sign_bit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive a new input set away from the rising edge, then wait until the result is observable.
    task automatic applyStimulus(input logic [2:0] m, input logic [15:0] a, input logic v);
        @(negedge clk);
        mode     = m;
        A        = a;
        in_valid = v;
`ifdef SIGN_EXTEND_REG_OUT_EN
        @(posedge clk);
`endif
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        A        = '0;
        mode     = 3'b000;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

`ifdef SIGN_EXTEND_REG_OUT_EN
        checkOutput("reset_B", B, 32'h0);
        checkOutput("reset_sign_bit", {31'b0, sign_bit}, 32'h0);
        checkOutput("reset_out_valid", {31'b0, out_valid}, 32'h0);
`else
        applyStimulus(3'b000, 16'h8000, 1'b1);
        checkOutput("rst_ignored_B", B, 32'hFFFF8000);
        checkOutput("rst_ignored_sign_bit", {31'b0, sign_bit}, 32'h1);
        checkOutput("rst_ignored_out_valid", {31'b0, out_valid}, 32'h1);
`endif

        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].mode, vecs[i].a, 1'b1);
            checkOutput($sformatf("vec%0d_B", i), B, vecs[i].b);
            checkOutput($sformatf("vec%0d_sign_bit", i), {31'b0, sign_bit}, {31'b0, vecs[i].sb});
            checkOutput($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, 32'h1);
        end

`ifdef SIGN_EXTEND_REG_OUT_EN
        applyStimulus(3'b000, 16'hFFFE, 1'b1);
        checkOutput("load_B", B, 32'hFFFFFFFE);
        checkOutput("load_out_valid", {31'b0, out_valid}, 32'h1);
        applyStimulus(3'b001, 16'h0001, 1'b0);
        checkOutput("hold_B", B, 32'hFFFFFFFE);
        checkOutput("hold_sign_bit", {31'b0, sign_bit}, 32'h1);
        checkOutput("hold_out_valid", {31'b0, out_valid}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(3'b000, 16'h8000, 1'b1);
        checkOutput("rst_wins_B", B, 32'h0);
        checkOutput("rst_wins_sign_bit", {31'b0, sign_bit}, 32'h0);
        checkOutput("rst_wins_out_valid", {31'b0, out_valid}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
`else
        applyStimulus(3'b001, 16'h00AB, 1'b0);
        checkOutput("invalid_B", B, 32'h000000AB);
        checkOutput("invalid_out_valid", {31'b0, out_valid}, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule

// File: doc/sign_extend.md
SIGN_EXTEND -- requirements
Module: sign_extend

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk is the clock, rst is the reset.
REQ-002 Parameter IN_W, default 16: immediate input width.
REQ-003 Parameter OUT_W, default 32: extended output width; SHALL be at least IN_W+2.
REQ-004 Port clk  input  1: rising-edge clock.
REQ-005 Port rst  input  1: synchronous active-high reset.
REQ-006 Port A  input  IN_W: immediate field to extend.
REQ-007 Port mode  input  3: extension operation select.
REQ-008 Port in_valid  input  1: A/mode qualify this cycle.
REQ-009 Port B  output  OUT_W: extended result.
REQ-010 Port out_valid  output  1: B qualifies this cycle.
REQ-011 Port sign_bit  output  1: fill bit used for the current B (0 for zero-fill modes).

Function
REQ-012 mode 000 SHALL produce sign extension: B = {(OUT_W-IN_W){A[IN_W-1]}, A}.
REQ-013 mode 001 SHALL produce zero extension: B = {0..., A}.
REQ-014 mode 010 SHALL produce upper placement: B = {A, (OUT_W-IN_W) zeros} (load-upper form).
REQ-015 mode 011 SHALL sign-extend the low byte: B = {fill of A[7], A[7:0]}.
REQ-016 mode 100 SHALL zero-extend the low byte: B = {0..., A[7:0]}.
REQ-017 mode 101 SHALL sign-extend then shift left 2 (branch offset): B = {fill of A[IN_W-1], A, 2'b00}, truncated to OUT_W.
REQ-018 modes 110 and 111 SHALL behave as mode 000.
REQ-019 sign_bit SHALL equal the fill bit of the selected mode (A[IN_W-1] for 000/101/110/111, A[7] for 011, 0 otherwise).
REQ-020 The datapath SHALL be purely combinational from A/mode to the pre-register result; no arithmetic overflow or saturation exists.
REQ-021 When in_valid is 0 the combinational result SHALL still be computed; only out_valid marks qualification.

Reset
REQ-022 With the output register compiled in, rst SHALL set B to 0, sign_bit to 0 and out_valid to 0 on the next rising clk edge.
REQ-023 rst asserted in the same cycle as in_valid SHALL win; that input is dropped.
REQ-024 Without the output register, rst SHALL have no effect on B, sign_bit or out_valid.

Configuration
REQ-025 Macro SIGN_EXTEND_REG_OUT_EN, when defined, SHALL insert one output register stage: B, sign_bit and out_valid update on rising clk with latency 1; out_valid = in_valid delayed one cycle; B and sign_bit load every cycle in_valid is 1 and hold otherwise.
REQ-026 When SIGN_EXTEND_REG_OUT_EN is undefined, B and sign_bit SHALL be combinational from A/mode (zero latency) and out_valid SHALL equal in_valid.

Verification
REQ-027 Macro undefined, mode=000, A=16'h7FFF -> B=32'h00007FFF, sign_bit=0 immediately.
REQ-028 mode=000, A=16'h8000 -> B=32'hFFFF8000, sign_bit=1; mode=001 same A -> B=32'h00008000, sign_bit=0.
REQ-029 mode=010, A=16'h1234 -> B=32'h12340000; mode=011, A=16'h0080 -> B=32'hFFFFFF80; mode=100, A=16'h00FF -> B=32'h000000FF.
REQ-030 mode=101, A=16'hFFFF -> B=32'hFFFFFFFC; A=16'h0001 -> B=32'h00000004.
REQ-031 Macro defined: in_valid=1, mode=000, A=16'hFFFE at edge N -> B=32'hFFFFFFFE, out_valid=1 after edge N; in_valid=0 at edge N+1 -> out_valid=0, B held.
REQ-032 Macro defined: rst=1 together with in_valid=1, A=16'h8000 -> after edge B=0, sign_bit=0, out_valid=0.
